// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing constants for the ultrasonic sensor front end.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned TRIG_US       = 10;
  localparam int unsigned TIMEOUT_US    = 38_000;
  localparam int unsigned HOLDOFF_US    = 60_000;
  localparam int unsigned CYCLES_PER_US = CLK_HZ / 1_000_000;

  function automatic int unsigned us_to_cycles(input int unsigned us);
    return us * CYCLES_PER_US;
  endfunction

  localparam int unsigned TRIG_CYCLES_DEF    = us_to_cycles(TRIG_US);
  localparam int unsigned TIMEOUT_CYCLES_DEF = us_to_cycles(TIMEOUT_US);
  localparam int unsigned HOLDOFF_CYCLES_DEF = us_to_cycles(HOLDOFF_US);
  localparam int unsigned COUNT_W_DEF        = 22;

endpackage

// File: rtl/cycle_timer.sv
// Loadable up-counter with clear, enable and a terminal-count compare.
module cycle_timer #(
  parameter int unsigned COUNT_W = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               enable,
  input  logic [COUNT_W-1:0] terminal,
  output logic [COUNT_W-1:0] count,
  output logic               at_terminal
);

  logic [COUNT_W-1:0] count_q, count_d;

  // Next count: clear beats load beats enable.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign at_terminal = (count_q == terminal);

endmodule

// File: rtl/ultrasonic_trigger.sv
// Trigger pulse generator and echo-width timer for an ultrasonic ranging sensor.
module ultrasonic_trigger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int unsigned COUNT_W        = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               echo,
  output logic               trig,
  output logic               busy,
  output logic [COUNT_W-1:0] echo_cycles,
  output logic               valid,
  output logic               timeout
);

  state_t             state_q, state_d;
  logic               echo_q;
  logic [COUNT_W-1:0] echo_cycles_q, echo_cycles_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  logic               tmr_clear, tmr_load, tmr_enable, tmr_at_term;
  logic [COUNT_W-1:0] tmr_load_value, tmr_terminal, tmr_count;
  logic               echo_rise;

  assign echo_rise = echo & ~echo_q;

  cycle_timer #(
    .COUNT_W(COUNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (tmr_clear),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .enable     (tmr_enable),
    .terminal   (tmr_terminal),
    .count      (tmr_count),
    .at_terminal(tmr_at_term)
  );

  // Next-state, timer control and result capture.
  always_comb begin
    state_d        = state_q;
    echo_cycles_d  = echo_cycles_q;
    valid_d        = 1'b0;
    timeout_d      = timeout_q;
    tmr_clear      = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    tmr_enable     = 1'b0;
    tmr_terminal   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = TRIG;
          tmr_clear = 1'b1;
        end
      end
      TRIG: begin
        tmr_terminal = COUNT_W'(TRIG_CYCLES - 1);
        if (tmr_at_term) begin
          state_d   = WAIT_RISE;
          tmr_clear = 1'b1;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      WAIT_RISE: begin
        tmr_terminal = COUNT_W'(TIMEOUT_CYCLES);
        if (echo_rise) begin
          // The edge cycle is the first high cycle, so the count starts at 1.
          state_d        = MEASURE;
          tmr_load       = 1'b1;
          tmr_load_value = COUNT_W'(1);
        end else if (tmr_at_term) begin
          state_d       = HOLDOFF;
          tmr_clear     = 1'b1;
          valid_d       = 1'b1;
          timeout_d     = 1'b1;
          echo_cycles_d = '0;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      MEASURE: begin
        tmr_terminal = COUNT_W'(TIMEOUT_CYCLES);
        if (!echo || tmr_at_term) begin
          // Falling echo wins at the terminal count; the count never passes it.
          state_d       = HOLDOFF;
          tmr_clear     = 1'b1;
          valid_d       = 1'b1;
          timeout_d     = echo;
          echo_cycles_d = tmr_count;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      HOLDOFF: begin
        tmr_terminal = COUNT_W'(HOLDOFF_CYCLES - 1);
        if (tmr_at_term) begin
          state_d = IDLE;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, echo history and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      echo_q        <= 1'b0;
      echo_cycles_q <= '0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      echo_q        <= echo;
      echo_cycles_q <= echo_cycles_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign trig        = (state_q == TRIG);
  assign busy        = (state_q != IDLE);
  assign echo_cycles = echo_cycles_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ultrasonic_trigger.sv
// Self-checking bench for ultrasonic_trigger: directed scenarios followed by
// random start/echo/reset traffic, compared against a timeline-based reference.
module tb_ultrasonic_trigger;

  localparam int TRIG = 5;
  localparam int TMO  = 100;
  localparam int HOLD = 20;
  localparam int CW   = 8;
  localparam int NCYC = 4000;
  localparam int MAXC = NCYC + 400;

  logic          clk = 1'b0;
  logic          reset, start, echo;
  logic          trig, busy, valid, timeout;
  logic [CW-1:0] echo_cycles;

  always #5 clk = ~clk;

  ultrasonic_trigger #(
    .TRIG_CYCLES   (TRIG),
    .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLD),
    .COUNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .echo       (echo),
    .trig       (trig),
    .busy       (busy),
    .echo_cycles(echo_cycles),
    .valid      (valid),
    .timeout    (timeout)
  );

  // Stimulus per cycle, and expected outputs as observed during each cycle.
  bit s_start [MAXC];
  bit s_reset [MAXC];
  bit s_echo  [MAXC];
  bit e_trig  [MAXC];
  bit e_busy  [MAXC];
  bit e_valid [MAXC];
  bit e_to    [MAXC];
  int e_ec    [MAXC];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_echo(input int from, input int upto, input bit val);
    for (int k = from; k <= upto; k++) s_echo[k] = val;
  endtask

  task automatic set_idle(input int k, input int ec, input bit to);
    if (k < MAXC) begin
      e_trig[k]  = 1'b0;
      e_busy[k]  = 1'b0;
      e_valid[k] = 1'b0;
      e_ec[k]    = ec;
      e_to[k]    = to;
    end
  endtask

  // Reference: for each accepted start, derive the whole measurement timeline
  // (trigger window, echo edge search, result cycle, holdoff end) by scanning
  // the echo waveform, then truncate it at the first reset.
  task automatic build_model();
    int  c, hold_ec, n, w, e, f, v, len, idle_at, stop;
    bit  hold_to, tmo, aborted;
    c = 0; hold_ec = 0; hold_to = 1'b0;
    while (c < NCYC) begin
      if (s_reset[c] || !s_start[c]) begin
        if (s_reset[c]) begin
          hold_ec = 0;
          hold_to = 1'b0;
        end
        set_idle(c + 1, hold_ec, hold_to);
        c++;
      end else begin
        n = c;
        w = n + TRIG + 1;
        e = -1;
        for (int k = w; k <= w + TMO; k++)
          if (e < 0 && s_echo[k] && !s_echo[k-1]) e = k;
        if (e < 0) begin
          v = w + TMO + 1; len = 0; tmo = 1'b1;
        end else begin
          f = -1;
          for (int k = e + 1; k <= e + TMO; k++)
            if (f < 0 && !s_echo[k]) f = k;
          if (f < 0) begin
            v = e + TMO + 1; len = TMO; tmo = 1'b1;
          end else begin
            v = f + 1; len = f - e; tmo = 1'b0;
          end
        end
        idle_at = v + HOLD;
        stop    = idle_at;
        aborted = 1'b0;
        for (int k = n + 1; k < idle_at; k++)
          if (!aborted && s_reset[k]) begin
            aborted = 1'b1;
            stop    = k + 1;
          end
        for (int k = n + 1; k < stop; k++) begin
          if (k == v) begin
            hold_ec = len;
            hold_to = tmo;
          end
          if (k < MAXC) begin
            e_trig[k]  = (k <= n + TRIG);
            e_busy[k]  = 1'b1;
            e_valid[k] = (k == v);
            e_ec[k]    = hold_ec;
            e_to[k]    = hold_to;
          end
        end
        if (aborted) begin
          hold_ec = 0;
          hold_to = 1'b0;
        end
        set_idle(stop, hold_ec, hold_to);
        c = stop;
      end
    end
  endtask

  task automatic build_stimulus();
    int  k, run;
    bit  lvl;
    // Power-on reset.
    for (int i = 0; i < 3; i++) s_reset[i] = 1'b1;
    // Nominal, with ignored starts in TRIG, MEASURE and HOLDOFF.
    s_start[10] = 1'b1;
    s_start[12] = 1'b1;
    s_start[50] = 1'b1;
    s_start[85] = 1'b1;
    set_echo(40, 76, 1'b1);
    // Start right after busy falls; no echo follows.
    s_start[99] = 1'b1;
    // Stuck echo.
    s_start[230] = 1'b1;
    set_echo(250, 399, 1'b1);
    // Reset during MEASURE, then a fresh measurement.
    s_start[420] = 1'b1;
    set_echo(440, 499, 1'b1);
    s_reset[460] = 1'b1;
    s_start[520] = 1'b1;
    set_echo(540, 562, 1'b1);
    // Echo already high on entry to WAIT_RISE.
    set_echo(590, 799, 1'b1);
    s_start[600] = 1'b1;
    // Echo high for exactly TMO cycles.
    s_start[820] = 1'b1;
    set_echo(830, 929, 1'b1);
    // Random traffic.
    k = 1000; lvl = 1'b0;
    while (k < MAXC) begin
      if ($urandom_range(0, 4) == 0) run = $urandom_range(95, 130);
      else                           run = $urandom_range(1, 40);
      for (int i = 0; i < run && k < MAXC; i++) begin
        s_echo[k] = lvl;
        k++;
      end
      lvl = ~lvl;
    end
    for (int i = 1000; i < NCYC; i++) begin
      s_start[i] = ($urandom_range(0, 39) == 0);
      s_reset[i] = ($urandom_range(0, 699) == 0);
    end
  endtask

  task automatic drive(input int c);
    reset = s_reset[c];
    start = s_start[c];
    echo  = s_echo[c];
  endtask

  initial begin
    build_stimulus();
    build_model();
    drive(0);
    for (int c = 1; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      check_eq("trig",        32'(trig),        32'(e_trig[c]));
      check_eq("busy",        32'(busy),        32'(e_busy[c]));
      check_eq("valid",       32'(valid),       32'(e_valid[c]));
      check_eq("timeout",     32'(timeout),     32'(e_to[c]));
      check_eq("echo_cycles", 32'(echo_cycles), e_ec[c]);
      // Fixed scenario landmarks.
      case (c)
        15:  check_eq("nom_trig_last",  32'(trig), 32'd1);
        16:  check_eq("nom_trig_drop",  32'(trig), 32'd0);
        78: begin
          check_eq("nom_valid", 32'(valid),       32'd1);
          check_eq("nom_ec",    32'(echo_cycles), 32'd37);
          check_eq("nom_to",    32'(timeout),     32'd0);
        end
        98:  check_eq("nom_busy_low",   32'(busy), 32'd0);
        100: check_eq("restart_trig",   32'(trig), 32'd1);
        206: begin
          check_eq("noecho_valid", 32'(valid),       32'd1);
          check_eq("noecho_ec",    32'(echo_cycles), 32'd0);
          check_eq("noecho_to",    32'(timeout),     32'd1);
        end
        351: begin
          check_eq("stuck_ec", 32'(echo_cycles), 32'd100);
          check_eq("stuck_to", 32'(timeout),     32'd1);
        end
        461: begin
          check_eq("rst_busy", 32'(busy),  32'd0);
          check_eq("rst_ec",   32'(echo_cycles), 32'd0);
        end
        564: check_eq("fresh_ec",       32'(echo_cycles), 32'd23);
        707: check_eq("highentry_to",   32'(timeout),     32'd1);
        931: begin
          check_eq("exact_ec", 32'(echo_cycles), 32'd100);
          check_eq("exact_to", 32'(timeout),     32'd0);
        end
        default: ;
      endcase
      drive(c);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
